mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  MEM-stage data-memory access controller of the 5-stage RV32I pipeline. Takes the
//  EX/MEM-registered load/store, drives the data-cache port (request/resp handshake),
//  aligns store data/byte mask, extends load data and produces mem_rdata/mem_addr for
//  the MEM/WB register. Stalls the whole pipeline while an access is outstanding.
// PARAMETERS
//  WATCHDOG_CYCLES  0  cycles in BUSY without dmem_resp before bus_timeout sets; 0 = disabled
// PORTS
//  clk            in   1   clock; all state on posedge
//  rst            in   1   synchronous, active-high reset
//  valid          in   1   EX/MEM holds a live instruction
//  mem_read       in   1   instruction is a load
//  mem_write      in   1   instruction is a store
//  funct3         in   3   load_funct3/store_funct3 encoding (b/h/w/bu/hu)
//  addr           in   32  byte address (ALU result)
//  store_data     in   32  rs2 value, unaligned
//  flush          in   1   kill current instruction (branch/jump redirect)
//  dmem_read      out  1   cache read request, registered
//  dmem_write     out  1   cache write request, registered
//  dmem_address   out  32  {addr[31:2],2'b00}, registered
//  dmem_wdata     out  32  store_data << (8*addr[1:0]), registered
//  dmem_mbe       out  4   byte enables, registered
//  dmem_rdata     in   32  cache read data, valid with dmem_resp
//  dmem_resp      in   1   one-cycle completion pulse
//  mem_rdata      out  32  extended load result to MEM/WB
//  mem_addr       out  32  original unaligned addr, passed through combinationally
//  misaligned     out  1   current access misaligned; no bus access made
//  stall          out  1   freeze PC and all pipeline registers (MEM/WB load = ~stall)
//  bus_timeout    out  1   sticky watchdog error, cleared only by rst
// BEHAVIOUR
//  Reset: state=IDLE; dmem_read/write=0, dmem_address/wdata=0, dmem_mbe=0,
//   mem_rdata=0, bus_timeout=0, watchdog count=0.
//  access = valid & (mem_read|mem_write) & ~misaligned & ~flush.
//  misaligned: h/hu with addr[0]=1, w with addr[1:0]!=0; forces stall=0, mem_rdata=0.
//  IDLE: stall = access. On access: latch request regs (mask sb 4'b0001<<a, sh
//   4'b0011<<a, sw 4'b1111), goto BUSY. Loads drive dmem_mbe=4'b1111.
//  BUSY: stall=1; requests held stable until dmem_resp sampled high; on resp drop
//   requests next edge; load: mem_rdata <= extend(dmem_rdata >> 8*addr[1:0]); goto DONE.
//  DONE: stall=0 for exactly one cycle so pipeline advances; no new request may start
//   (the same instruction is still presented); goto IDLE.
//  Latency: resp in first BUSY cycle -> DONE 2 cycles after access seen; stall high
//   2 + (resp wait) cycles. Stores update mem_rdata? No: mem_rdata holds old value.
//  Extension: lb/lh sign-extend bit 7/15; lbu/lhu zero-extend; lw unchanged.
//  flush in IDLE: no access. flush in BUSY: transaction still completes (no abort),
//   kill flag set, stall stays 1 until resp, then go IDLE (skip DONE), mem_rdata unchanged.
//  mem_read & mem_write both set: treated as load. dmem_resp outside BUSY: ignored.
//  Watchdog: counts BUSY cycles, resets on leaving BUSY; at WATCHDOG_CYCLES sets
//   bus_timeout; FSM keeps waiting.
//  rst mid-BUSY: requests drop at that edge, state IDLE, late dmem_resp ignored.
// STRUCTURE
//  rv32i_types: mem_ctrl_state_t enum {IDLE,BUSY,DONE}; load_funct3_t/store_funct3_t
//   reused. Sub-module mem_align (combinational: mbe/wdata shift, load extend, misaligned).
// TESTING
//  lw addr 0x100, resp after 3 BUSY cycles, rdata 0xDEADBEEF -> mem_rdata 0xDEADBEEF, stall 5 cycles.
//  lb addr 0x103, rdata 0x80FF_0000 -> mem_rdata 0xFFFFFF80; lbu same -> 0x00000080.
//  sh addr 0x102 data 0x0000ABCD -> dmem_mbe 4'b1100, dmem_wdata 0xABCD0000, address 0x100.
//  lw addr 0x101 -> misaligned=1, stall=0, no dmem_read ever asserted.
//  flush in 2nd BUSY cycle -> requests held to resp, no DONE, mem_rdata unchanged.
//  WATCHDOG_CYCLES=4, no resp -> bus_timeout=1 after 4 BUSY cycles; rst clears all.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory controller.
// - mem_ctrl_state_t: access FSM states.
// - load_funct3_t, store_funct3_t: RV32I load/store funct3 encodings.
package mem_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_ctrl_state_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

endpackage

// File: rtl/mem_align.sv
// Combinational alignment helpers for the MEM stage.
// Request side (current EX/MEM instruction):
//   funct3, offset, store_data, is_load -> mbe, wdata, misaligned_addr
// Response side (latched request attributes):
//   ld_funct3, ld_offset, ld_raw -> ld_ext (shifted and sign/zero extended)
module mem_align
    import mem_stage_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic        is_load,
    output logic [3:0]  mbe,
    output logic [31:0] wdata,
    output logic        misaligned_addr,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_ext
);
    logic [31:0] ld_shifted;

    always_comb begin
        wdata = store_data << {offset, 3'b000};
        mbe   = 4'b1111;
        if (!is_load) begin
            case (store_funct3_t'(funct3))
                SB:      mbe = 4'b0001 << offset;
                SH:      mbe = 4'b0011 << offset;
                default: mbe = 4'b1111;
            endcase
        end
        // funct3[1:0] is the access size for both loads and stores.
        case (funct3[1:0])
            2'b01:   misaligned_addr = offset[0];
            2'b10:   misaligned_addr = |offset;
            default: misaligned_addr = 1'b0;
        endcase
    end

    always_comb begin
        ld_shifted = ld_raw >> {ld_offset, 3'b000};
        case (load_funct3_t'(ld_funct3))
            LB:      ld_ext = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            LH:      ld_ext = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            LBU:     ld_ext = {24'b0, ld_shifted[7:0]};
            LHU:     ld_ext = {16'b0, ld_shifted[15:0]};
            default: ld_ext = ld_shifted;
        endcase
    end
endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory access controller (RV32I 5-stage pipeline).
// Takes the EX/MEM load/store, issues one registered request to the data
// cache, waits for the dmem_resp pulse, and stalls the pipeline meanwhile.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   valid, mem_read, mem_write  EX/MEM instruction qualifiers
//   funct3, addr, store_data    access size/sign, byte address, raw rs2
//   flush                       kill current instruction
//   dmem_*                      registered cache request, rdata/resp back
//   mem_rdata, mem_addr         load result / passthrough address to MEM/WB
//   misaligned, stall           access status to the pipeline
//   bus_timeout                 sticky watchdog error (0 cycles = disabled)
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned WATCHDOG_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic        flush,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_mbe,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        misaligned,
    output logic        stall,
    output logic        bus_timeout
);
    mem_ctrl_state_t state, state_nxt;

    logic        is_load, misaligned_addr, access, killed;
    logic        ld_q, kill_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [3:0]  mbe_a;
    logic [31:0] wdata_a, ld_ext, mem_rdata_q, wd_cnt;

    // A combined read+write request is handled as a load.
    assign is_load    = mem_read;
    assign misaligned = valid & (mem_read | mem_write) & misaligned_addr;
    assign access     = valid & (mem_read | mem_write) & ~misaligned_addr & ~flush;
    assign killed     = kill_q | flush;
    assign mem_addr   = addr;
    assign mem_rdata  = misaligned ? 32'b0 : mem_rdata_q;

    mem_align u_align (
        .funct3          (funct3),
        .offset          (addr[1:0]),
        .store_data      (store_data),
        .is_load         (is_load),
        .mbe             (mbe_a),
        .wdata           (wdata_a),
        .misaligned_addr (misaligned_addr),
        .ld_funct3       (f3_q),
        .ld_offset       (off_q),
        .ld_raw          (dmem_rdata),
        .ld_ext          (ld_ext)
    );

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = access;
                if (access) state_nxt = BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                // A killed access still finishes on the bus but skips DONE,
                // so the pipeline never sees a completion for it.
                if (dmem_resp) state_nxt = killed ? IDLE : DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            dmem_address <= '0;
            dmem_wdata   <= '0;
            dmem_mbe     <= '0;
            mem_rdata_q  <= '0;
            bus_timeout  <= 1'b0;
            wd_cnt       <= '0;
            ld_q         <= 1'b0;
            kill_q       <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (access) begin
                        dmem_read    <= is_load;
                        dmem_write   <= ~is_load;
                        dmem_address <= {addr[31:2], 2'b00};
                        dmem_wdata   <= wdata_a;
                        dmem_mbe     <= mbe_a;
                        ld_q         <= is_load;
                        f3_q         <= funct3;
                        off_q        <= addr[1:0];
                        kill_q       <= 1'b0;
                    end
                end
                BUSY: begin
                    if (flush) kill_q <= 1'b1;
                    if (dmem_resp) begin
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        if (ld_q && !killed) mem_rdata_q <= ld_ext;
                    end
                end
                default: ;
            endcase

            // wd_cnt holds the number of BUSY cycles already spent without a response.
            if (state == BUSY && !dmem_resp) begin
                if (wd_cnt != '1) wd_cnt <= wd_cnt + 32'd1;
                if (WATCHDOG_CYCLES != 0 && wd_cnt >= WATCHDOG_CYCLES - 1)
                    bus_timeout <= 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus a
// randomized load/store sweep checked against a byte-level reference model.
module tb_mem_stage_ctrl;
    logic        clk = 1'b0;
    logic        rst, valid, mem_read, mem_write, flush, dmem_resp;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, dmem_rdata;
    logic        dmem_read, dmem_write, misaligned, stall, bus_timeout;
    logic [31:0] dmem_address, dmem_wdata, mem_rdata, mem_addr;
    logic [3:0]  dmem_mbe;

    int total = 0, passed = 0;
    logic [31:0] model_rdata = 32'h0;

    // captured by run_access
    int          stall_n, bus_n;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_mbe;
    logic        c_rd, c_wr;

    mem_stage_ctrl #(.WATCHDOG_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .valid(valid), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data), .flush(flush),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
        .misaligned(misaligned), .stall(stall), .bus_timeout(bus_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] raw);
        logic [31:0] s;
        s = raw >> (8 * off);
        case (f3)
            3'd0:    return 32'(int'(byte'(s[7:0])));
            3'd1:    return 32'(int'(shortint'(s[15:0])));
            3'd4:    return s & 32'h0000_00FF;
            3'd5:    return s & 32'h0000_FFFF;
            default: return raw;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid = 0; mem_read = 0; mem_write = 0; flush = 0; dmem_resp = 0;
    endtask

    // Presents one access and services it, answering on BUSY cycle waitc+1.
    // Returns with the DUT in the cycle where stall first drops (DONE).
    task automatic run_access(input bit ld, input bit both, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rd, input int waitc);
        valid = 1; mem_read = ld; mem_write = !ld || both; funct3 = f3;
        addr = a; store_data = sd; dmem_rdata = rd;
        #1;
        stall_n = 0; bus_n = 0; c_rd = 0; c_wr = 0; c_addr = 0; c_wdata = 0; c_mbe = 0;
        for (int c = 0; c < 40; c++) begin
            if (!stall) break;
            stall_n++;
            if (dmem_read || dmem_write) begin
                c_rd = c_rd | dmem_read; c_wr = c_wr | dmem_write;
                c_addr = dmem_address; c_wdata = dmem_wdata; c_mbe = dmem_mbe;
                if (bus_n == waitc) dmem_resp = 1;
                bus_n++;
            end
            step();
            dmem_resp = 0;
        end
    endtask

    task automatic finish_access();
        idle_inputs();
        step();
    endtask

    task automatic test_reset();
        idle_inputs(); funct3 = 0; addr = 0; store_data = 0; dmem_rdata = 0;
        rst = 1;
        step(); step();
        rst = 0;
        #1;
        total++; if (dmem_read !== 1'b0) $display("FAIL reset_dmem_read got %b want 0", dmem_read); else passed++;
        total++; if (dmem_write !== 1'b0) $display("FAIL reset_dmem_write got %b want 0", dmem_write); else passed++;
        total++; if (dmem_address !== 32'h0) $display("FAIL reset_dmem_address got %h want 0", dmem_address); else passed++;
        total++; if (dmem_wdata !== 32'h0) $display("FAIL reset_dmem_wdata got %h want 0", dmem_wdata); else passed++;
        total++; if (dmem_mbe !== 4'h0) $display("FAIL reset_dmem_mbe got %h want 0", dmem_mbe); else passed++;
        total++; if (mem_rdata !== 32'h0) $display("FAIL reset_mem_rdata got %h want 0", mem_rdata); else passed++;
        total++; if (bus_timeout !== 1'b0) $display("FAIL reset_bus_timeout got %b want 0", bus_timeout); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else passed++;
        model_rdata = 0;
    endtask

    task automatic test_lw();
        run_access(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 3);
        total++; if (mem_rdata !== 32'hDEAD_BEEF) $display("FAIL lw_rdata got %h want deadbeef", mem_rdata); else passed++;
        total++; if (stall_n != 5) $display("FAIL lw_stall_cycles got %0d want 5", stall_n); else passed++;
        total++; if (c_addr !== 32'h100 || c_mbe !== 4'hF) $display("FAIL lw_request got addr %h mbe %h want 100 f", c_addr, c_mbe); else passed++;
        total++; if (c_rd !== 1'b1 || c_wr !== 1'b0) $display("FAIL lw_kind got rd %b wr %b want 1 0", c_rd, c_wr); else passed++;
        total++; if (mem_addr !== 32'h100) $display("FAIL lw_mem_addr got %h want 100", mem_addr); else passed++;
        finish_access();
        total++; if (dmem_read !== 1'b0) $display("FAIL lw_req_drop got %b want 0", dmem_read); else passed++;
    endtask

    task automatic test_lb_lbu();
        run_access(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 0);
        total++; if (mem_rdata !== 32'hFFFF_FF80) $display("FAIL lb_rdata got %h want ffffff80", mem_rdata); else passed++;
        total++; if (stall_n != 2) $display("FAIL lb_stall_cycles got %0d want 2", stall_n); else passed++;
        finish_access();
        run_access(1, 0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 0);
        total++; if (mem_rdata !== 32'h0000_0080) $display("FAIL lbu_rdata got %h want 00000080", mem_rdata); else passed++;
        finish_access();
        model_rdata = 32'h0000_0080;
    endtask

    task automatic test_sh();
        run_access(0, 0, 3'd1, 32'h102, 32'h0000_ABCD, 32'h1234_5678, 1);
        total++; if (c_mbe !== 4'b1100) $display("FAIL sh_mbe got %b want 1100", c_mbe); else passed++;
        total++; if (c_wdata !== 32'hABCD_0000) $display("FAIL sh_wdata got %h want abcd0000", c_wdata); else passed++;
        total++; if (c_addr !== 32'h100) $display("FAIL sh_address got %h want 100", c_addr); else passed++;
        total++; if (c_wr !== 1'b1 || c_rd !== 1'b0) $display("FAIL sh_kind got rd %b wr %b want 0 1", c_rd, c_wr); else passed++;
        total++; if (mem_rdata !== model_rdata) $display("FAIL sh_rdata_hold got %h want %h", mem_rdata, model_rdata); else passed++;
        finish_access();
    endtask

    task automatic test_misaligned();
        logic seen;
        seen = 0;
        valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'd2; addr = 32'h101;
        #1;
        total++; if (misaligned !== 1'b1) $display("FAIL mis_flag got %b want 1", misaligned); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL mis_stall got %b want 0", stall); else passed++;
        total++; if (mem_rdata !== 32'h0) $display("FAIL mis_rdata got %h want 0", mem_rdata); else passed++;
        for (int i = 0; i < 3; i++) begin step(); seen = seen | dmem_read | dmem_write; end
        mem_read = 0; mem_write = 1; funct3 = 3'd1; addr = 32'h203;
        for (int i = 0; i < 3; i++) begin step(); seen = seen | dmem_read | dmem_write; end
        total++; if (seen !== 1'b0) $display("FAIL mis_no_bus got %b want 0", seen); else passed++;
        idle_inputs();
        #1;
        total++; if (mem_rdata !== model_rdata) $display("FAIL mis_rdata_restore got %h want %h", mem_rdata, model_rdata); else passed++;
    endtask

    task automatic test_resp_idle();
        dmem_rdata = $urandom(); dmem_resp = 1;
        step();
        dmem_resp = 0;
        total++; if (mem_rdata !== model_rdata) $display("FAIL idle_resp got %h want %h", mem_rdata, model_rdata); else passed++;
    endtask

    task automatic test_flush();
        // flush while idle: no access
        valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'd2; addr = 32'h200; flush = 1;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL flush_idle_stall got %b want 0", stall); else passed++;
        step();
        total++; if (dmem_read !== 1'b0) $display("FAIL flush_idle_req got %b want 0", dmem_read); else passed++;
        // flush in the second BUSY cycle
        flush = 0; dmem_rdata = 32'h5555_AAAA;
        step();   // BUSY 1
        step();   // BUSY 2
        flush = 1; valid = 0;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL flush_busy_stall got %b want 1", stall); else passed++;
        step();   // BUSY 3
        flush = 0;
        total++; if (dmem_read !== 1'b1 || stall !== 1'b1) $display("FAIL flush_hold got rd %b stall %b want 1 1", dmem_read, stall); else passed++;
        dmem_resp = 1;
        step();
        dmem_resp = 0;
        total++; if (dmem_read !== 1'b0) $display("FAIL flush_req_drop got %b want 0", dmem_read); else passed++;
        total++; if (mem_rdata !== model_rdata) $display("FAIL flush_rdata got %h want %h", mem_rdata, model_rdata); else passed++;
        // back in IDLE right away (no DONE): a new access is taken immediately
        run_access(1, 0, 3'd2, 32'h204, 32'h0, 32'h0BAD_F00D, 1);
        total++; if (stall_n != 3) $display("FAIL flush_no_done got %0d want 3", stall_n); else passed++;
        total++; if (mem_rdata !== 32'h0BAD_F00D) $display("FAIL flush_next_rdata got %h want 0badf00d", mem_rdata); else passed++;
        model_rdata = 32'h0BAD_F00D;
        finish_access();
    endtask

    task automatic test_random();
        bit ld, both;
        int k, sz, off, wt;
        logic [2:0]  f3;
        logic [31:0] a, sd, rd, exp_wdata;
        logic [3:0]  exp_mbe;
        for (int i = 0; i < 24; i++) begin
            ld = bit'($urandom_range(0, 1));
            both = ld && ($urandom_range(0, 3) == 0);
            k = $urandom_range(0, 4);
            f3 = ld ? 3'(k < 3 ? k : k + 1) : 3'($urandom_range(0, 2));
            sz = 1 << f3[1:0];
            off = ($urandom_range(0, 3) / sz) * sz;
            a = ($urandom() & 32'hFFFF_FFFC) | 32'(off);
            sd = $urandom(); rd = $urandom(); wt = $urandom_range(0, 2);
            exp_mbe = ld ? 4'hF : 4'(((1 << sz) - 1) << off);
            exp_wdata = sd << (8 * off);
            if (ld) model_rdata = ref_load(f3, off, rd);
            run_access(ld, both, f3, a, sd, rd, wt);
            total++; if (stall_n != wt + 2) $display("FAIL rnd%0d_stall got %0d want %0d", i, stall_n, wt + 2); else passed++;
            total++; if (c_addr !== a - 32'(off)) $display("FAIL rnd%0d_addr got %h want %h", i, c_addr, a - 32'(off)); else passed++;
            total++; if (c_mbe !== exp_mbe) $display("FAIL rnd%0d_mbe got %h want %h", i, c_mbe, exp_mbe); else passed++;
            total++; if (c_rd !== ld || c_wr !== !ld) $display("FAIL rnd%0d_kind got rd %b wr %b want ld %b", i, c_rd, c_wr, ld); else passed++;
            if (!ld) begin
                total++; if (c_wdata !== exp_wdata) $display("FAIL rnd%0d_wdata got %h want %h", i, c_wdata, exp_wdata); else passed++;
            end
            total++; if (mem_rdata !== model_rdata) $display("FAIL rnd%0d_rdata got %h want %h", i, mem_rdata, model_rdata); else passed++;
            finish_access();
        end
    endtask

    task automatic test_watchdog_and_reset();
        total++; if (bus_timeout !== 1'b0) $display("FAIL wd_pre got %b want 0", bus_timeout); else passed++;
        valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'd2; addr = 32'h300;
        #1;
        step(); valid = 0;              // BUSY 1
        step(); step(); step();         // BUSY 4
        total++; if (bus_timeout !== 1'b0) $display("FAIL wd_early got %b want 0", bus_timeout); else passed++;
        step();                         // BUSY 5: four resp-less cycles done
        total++; if (bus_timeout !== 1'b1) $display("FAIL wd_set got %b want 1", bus_timeout); else passed++;
        total++; if (stall !== 1'b1 || dmem_read !== 1'b1) $display("FAIL wd_wait got stall %b rd %b want 1 1", stall, dmem_read); else passed++;
        rst = 1;
        step();
        rst = 0;
        total++; if (dmem_read !== 1'b0 || stall !== 1'b0) $display("FAIL rst_busy got rd %b stall %b want 0 0", dmem_read, stall); else passed++;
        total++; if (bus_timeout !== 1'b0) $display("FAIL rst_timeout got %b want 0", bus_timeout); else passed++;
        total++; if (mem_rdata !== 32'h0 || dmem_mbe !== 4'h0) $display("FAIL rst_regs got rdata %h mbe %h want 0 0", mem_rdata, dmem_mbe); else passed++;
        dmem_rdata = 32'hCAFE_BABE; dmem_resp = 1;
        step();
        dmem_resp = 0;
        total++; if (mem_rdata !== 32'h0 || dmem_read !== 1'b0 || stall !== 1'b0) $display("FAIL late_resp got rdata %h rd %b stall %b want 0 0 0", mem_rdata, dmem_read, stall); else passed++;
        model_rdata = 0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh();
        test_misaligned();
        test_resp_idle();
        test_flush();
        test_random();
        test_watchdog_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
